fwd_stall_unit: RTL
===================

# fwd_stall_unit

Parametrised operand-forwarding and pipeline-stall controller for the 5-stage core; successor to the fixed two-port, EX/MEM-only forwarding path and the constant-zero stall controller. Sits between ID, the downstream stage buses and the stage registers. Every cycle it:
- resolves `NUM_RD` register-read ports against `NUM_SRC` in-flight write-back sources;
- detects load-use and multi-cycle-execute hazards and drives the stage stall vector;
- holds resolved operands across stall cycles, so that a source retiring during a stall cannot corrupt the operand.

## Interface
Parameters:
- `NUM_RD`, 2, number of register-read ports (rs, rt, ...)
- `NUM_SRC`, 3, forwarding sources; index 0 = EX (youngest), ascending = older (MEM, WB)
- `DW`, 32, data width
- `AW`, 5, register address width
- `STALL_W`, 6, stall bus width; bit 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB

Ports:
- `clk`, in, 1, sole clock, rising edge
- `rst`, in, 1, asynchronous active-low reset (0 = reset)
- `rd_addr`, in, `NUM_RD*AW`, read addresses; port i at `[i*AW +: AW]`
- `rd_used`, in, `NUM_RD`, port i operand actually consumed by the ID instruction
- `src_we`, in, `NUM_SRC`, source j writes the register file
- `src_waddr`, in, `NUM_SRC*AW`, source j destination
- `src_wdata`, in, `NUM_SRC*DW`, source j result
- `src_is_load`, in, 1, source 0 is a load (data not yet available)
- `ex_busy`, in, 1, multi-cycle EX operation in progress
- `fwd_sel`, out, `NUM_RD`, port i takes `fwd_data` instead of the RF value
- `fwd_data`, out, `NUM_RD*DW`, forwarded operand per port
- `stall`, out, `STALL_W`, pipeline stall vector
- `stall_cnt`, out, 32, saturating count of stalled cycles

## Operation
- **Match.** Port i matches source j when all hold: `rd_used[i]`, `src_we[j]`, `src_waddr[j]==rd_addr[i]`, `rd_addr[i]!=0`.
  - The lowest matching j wins (youngest value).
  - Register 0 never matches, forwards or stalls.
- **Load-use.** Any port matching source 0 while `src_is_load=1` asserts `stall = 000111` (bits 0..2): PC, IF/ID and ID/EX hold, and a bubble enters EX. Next cycle the load sits at source 1 and forwards normally.
- **Busy.** `ex_busy=1` asserts `stall = 001111`. Busy has priority over load-use.
- **No hazard.** `stall = 0`.
- **Stall FSM, 2 states:**
  - `RUN`: go to `HOLD` when `stall != 0`. On that edge, capture per port `hold_vld[i]` = `fwd_sel[i]` and `hold_data[i]` = `fwd_data[i]`. For a load-use hit on source 0, do not capture that port (`hold_vld=0`).
  - `HOLD`: stay while `stall != 0`. Each cycle:
    - a live match overrides and recaptures the hold register;
    - a port with no live match and `hold_vld=1` outputs `hold_data` with `fwd_sel=1`.
    - Return to `RUN` and clear all `hold_vld` on the first cycle with `stall = 0`; that cycle still uses held values where no live match exists.
- **Forwarding outputs.**
  - In `RUN`, `fwd_sel` and `fwd_data` are purely combinational from the current match.
  - A non-forwarded port outputs `fwd_data = 0`.
- **`stall_cnt`.** Increments every cycle with `stall != 0` and saturates at `FFFF_FFFF`.
- **Parameter legality.** `NUM_SRC >= 2` is required because load data comes from source 1; elaboration-time error otherwise.

## Timing
- **Reset** (`rst=0`, asynchronous):
  - state `RUN`, `hold_vld=0`, `hold_data=0`, `stall_cnt=0`;
  - `stall=0`, `fwd_sel=0`, `fwd_data=0` regardless of inputs while reset is held.
- **Combinational outputs.** `stall`, `fwd_sel` and `fwd_data` have zero latency from inputs in the same cycle.
- **Registered state.** FSM, hold registers and `stall_cnt` update on the rising edge.
- **Load-use timing.** A load-use stall lasts exactly 1 cycle unless busy overlaps. Busy stall length equals the number of `ex_busy` high cycles.
- **Simultaneous events:**
  - busy and load-use in the same cycle: stall is `001111`, and the load-use re-evaluates after busy drops;
  - two ports matching different sources: each resolves independently;
  - `rd_addr[0]==rd_addr[1]`: both ports receive identical results.
- **Reset mid-stall** drops `stall` immediately and discards held data.

## Test plan
- No hazard: `rd_addr={5,3}`, `rd_used=11`, all `src_we=0` -> `fwd_sel=00`, `stall=0`, `stall_cnt` stays 0.
- Priority:
  - stimulus: `rd_addr[0]=7`; src0 (`we=1`, addr 7, data `AAAA0000`); src1 (addr 7, data `11111111`);
  - required: `fwd_sel[0]=1`, `fwd_data[0]=AAAA0000`;
  - then with `rd_addr[0]=0`: `fwd_sel[0]=0`.
- Load-use:
  - cycle 1: src0 load (addr 9), `rd_addr[1]=9` -> `stall=000111` for exactly 1 cycle;
  - cycle 2: src1 (addr 9, data `DEADBEEF`) -> `fwd_data[1]=DEADBEEF`, `stall=0`, `stall_cnt=1`.
- Busy hold:
  - cycle 0: `ex_busy=1` for 4 cycles; port0 matches src2 (addr 4, data `12345678`);
  - cycle 1: src2 `we=0`;
  - required: `stall=001111` for 4 cycles, `fwd_sel[0]=1`, `fwd_data[0]=12345678` through the release cycle; next cycle `fwd_sel[0]=0`.
- Reset mid-busy: assert `rst=0` during the 3rd busy cycle -> `stall`, `fwd_sel`, `stall_cnt` all 0 immediately; after release with no hazard, stays in `RUN`.
- Saturation: force `stall_cnt` to `FFFF_FFFE`, then 3 busy cycles -> `FFFF_FFFF` held.

Source files
------------

// File: rtl/fwd_stall_unit.sv
// fwd_stall_unit
//   Operand-forwarding and pipeline-stall controller for the 5-stage core.
//   Resolves NUM_RD register-read ports against NUM_SRC in-flight write-back
//   sources (index 0 = EX, youngest), raises load-use / busy stalls and holds
//   resolved operands across stall cycles so a source retiring mid-stall
//   cannot corrupt an operand.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low (0 = reset)
//   rd_addr      read address per port, port i at [i*AW +: AW]
//   rd_used      port i operand is consumed by the ID instruction
//   src_we       source j writes the register file
//   src_waddr    source j destination register
//   src_wdata    source j result
//   src_is_load  source 0 is a load whose data is not yet available
//   ex_busy      multi-cycle EX operation in progress
//   fwd_sel      port i takes fwd_data instead of the register-file value
//   fwd_data     forwarded operand per port (0 when not forwarded)
//   stall        stall vector: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB
//   stall_cnt    saturating count of stalled cycles
module fwd_stall_unit #(
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned STALL_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  input  logic [NUM_RD-1:0]      rd_used,
  input  logic [NUM_SRC-1:0]     src_we,
  input  logic [NUM_SRC*AW-1:0]  src_waddr,
  input  logic [NUM_SRC*DW-1:0]  src_wdata,
  input  logic                   src_is_load,
  input  logic                   ex_busy,
  output logic [NUM_RD-1:0]      fwd_sel,
  output logic [NUM_RD*DW-1:0]   fwd_data,
  output logic [STALL_W-1:0]     stall,
  output logic [31:0]            stall_cnt
);

  // Load data is picked up from source 1 after the bubble, and the busy
  // pattern needs four stall bits.
  if (NUM_SRC < 2) begin : g_bad_num_src
    $error("fwd_stall_unit: NUM_SRC must be at least 2");
  end
  if (STALL_W < 4) begin : g_bad_stall_w
    $error("fwd_stall_unit: STALL_W must be at least 4");
  end

  localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(4'b0111);
  localparam logic [STALL_W-1:0] STALL_BUSY = STALL_W'(4'b1111);

  typedef enum logic {
    RUN,
    HOLD
  } state_t;

  state_t state_q, state_d;

  logic [NUM_RD-1:0]          live_hit;
  logic [NUM_RD-1:0]          load_hit;
  logic [NUM_RD-1:0][DW-1:0]  live_data;
  logic [NUM_RD-1:0]          hold_vld;
  logic [NUM_RD-1:0][DW-1:0]  hold_data;
  logic [STALL_W-1:0]         stall_c;
  logic [31:0]                cnt_q;

  // Per-port match: the first (youngest) matching source wins.
  always_comb begin
    live_hit  = '0;
    load_hit  = '0;
    live_data = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      for (int unsigned j = 0; j < NUM_SRC; j++) begin
        if (!live_hit[i] && rd_used[i] && src_we[j] &&
            (src_waddr[j*AW +: AW] == rd_addr[i*AW +: AW]) &&
            (rd_addr[i*AW +: AW] != '0)) begin
          live_hit[i]  = 1'b1;
          live_data[i] = src_wdata[j*DW +: DW];
          load_hit[i]  = (j == 0) && src_is_load;
        end
      end
    end
  end

  // Busy outranks load-use; a load-use masked by busy re-evaluates afterwards
  // because nothing about it is remembered.
  always_comb begin
    stall_c = '0;
    if (rst) begin
      if (ex_busy)
        stall_c = STALL_BUSY;
      else if (|load_hit)
        stall_c = STALL_LOAD;
    end
  end

  assign stall     = stall_c;
  assign stall_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:  if (stall_c != '0) state_d = HOLD;
      HOLD: if (stall_c == '0) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Live matches always win; held values fill in only while in HOLD,
  // including the release cycle.
  always_comb begin
    fwd_sel  = '0;
    fwd_data = '0;
    if (rst) begin
      for (int unsigned i = 0; i < NUM_RD; i++) begin
        if (live_hit[i]) begin
          fwd_sel[i]            = 1'b1;
          fwd_data[i*DW +: DW]  = live_data[i];
        end else if (state_q == HOLD && hold_vld[i]) begin
          fwd_sel[i]            = 1'b1;
          fwd_data[i*DW +: DW]  = hold_data[i];
        end
      end
    end
  end

  // A load hit from source 0 carries no valid data yet, so it clears rather
  // than fills the hold slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_vld  <= '0;
      hold_data <= '0;
    end else if (stall_c != '0) begin
      for (int unsigned i = 0; i < NUM_RD; i++) begin
        if (live_hit[i]) begin
          hold_vld[i]  <= !load_hit[i];
          hold_data[i] <= live_data[i];
        end else if (state_q == RUN) begin
          hold_vld[i]  <= 1'b0;
        end
      end
    end else begin
      hold_vld <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= '0;
    else if (stall_c != '0 && cnt_q != '1)
      cnt_q <= cnt_q + 32'd1;
  end

endmodule
